// File: rtl/ad9122_init_seq_if.sv
// Control, status and serial-port-stage handshake bundle for the AD9122 init sequencer.
interface ad9122_init_seq_if;
  logic        start;
  logic        user_wr_en;
  logic [6:0]  user_wr_addr;
  logic [7:0]  user_wr_data;
  logic        user_wr_ack;
  logic        config_en;
  logic [15:0] config_data;
  logic        config_end;
  logic        init_done;
  logic        busy;
  logic        timeout_err;
  logic [5:0]  cmd_index;

  // master = the sequencer, slave = the host / serial stage around it
  modport master (
    input  start, user_wr_en, user_wr_addr, user_wr_data, config_end,
    output user_wr_ack, config_en, config_data, init_done, busy, timeout_err, cmd_index
  );
  modport slave (
    output start, user_wr_en, user_wr_addr, user_wr_data, config_end,
    input  user_wr_ack, config_en, config_data, init_done, busy, timeout_err, cmd_index
  );
endinterface

// File: rtl/ad9122_init_seq.sv
// AD9122 power-up register sequencer: flushes the serial stage, streams a constant
// init table one frame at a time, then serves single runtime register writes.
module ad9122_init_seq #(
  parameter int NUM_CMDS       = 16,
  parameter int GAP_CYCLES     = 4,
  parameter int TIMEOUT_CYCLES = 255,
  parameter bit AUTO_START     = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  ad9122_init_seq_if.master bus
);
  localparam int FLUSH_CYCLES = 64;
  localparam int CNT_MAX = (TIMEOUT_CYCLES > FLUSH_CYCLES) ? TIMEOUT_CYCLES : FLUSH_CYCLES;
  localparam int CW = $clog2(CNT_MAX + GAP_CYCLES + 1);

  typedef enum logic [2:0] {FLUSH, IDLE, ISSUE, WAIT_END, GAP, READY, ERROR} state_t;

  state_t        state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [5:0]    idx, idx_d;
  logic [15:0]   data_q, data_d;
  logic          user_q, user_d, done_q, done_d, terr_q, terr_d, rerun_q, rerun_d;
  logic          ack_q, ack_d, en_q, start_q, start_rise, go_init;

  function automatic logic [15:0] table_word(input logic [5:0] i);
    case (i)
      6'd0:    return 16'h0020;
      6'd1:    return 16'h0000;
      6'd2:    return 16'h0100;
      6'd3:    return 16'h0300;
      6'd4:    return 16'h0400;
      6'd5:    return 16'h0500;
      6'd6:    return 16'h0A80;
      6'd7:    return 16'h0C12;
      6'd8:    return 16'h0D00;
      6'd9:    return 16'h1600;
      6'd10:   return 16'h17C0;
      6'd11:   return 16'h1B24;
      6'd12:   return 16'h1C00;
      6'd13:   return 16'h1D00;
      6'd14:   return 16'h1E00;
      6'd15:   return 16'h4000;
      default: return 16'h0000;
    endcase
  endfunction

  assign start_rise = bus.start & ~start_q;

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    idx_d   = idx;
    data_d  = data_q;
    user_d  = user_q;
    done_d  = done_q;
    terr_d  = terr_q;
    rerun_d = rerun_q;
    ack_d   = 1'b0;
    go_init = 1'b0;
    unique case (state)
      FLUSH:
        if (cnt == CW'(FLUSH_CYCLES - 1)) begin
          cnt_d   = '0;
          rerun_d = 1'b0;
          if (AUTO_START || rerun_q) go_init = 1'b1;
          else                       state_d = IDLE;
        end else cnt_d = cnt + 1'b1;
      IDLE:
        if (start_rise) go_init = 1'b1;
      ISSUE: begin
        // cnt tracks cycles elapsed since CONFIG_EN
        state_d = WAIT_END;
        cnt_d   = CW'(1);
      end
      WAIT_END:
        if (bus.config_end) begin
          state_d = GAP;
          cnt_d   = '0;
        end else if (cnt == CW'(TIMEOUT_CYCLES - 1)) begin
          state_d = ERROR;
          terr_d  = 1'b1;
        end else cnt_d = cnt + 1'b1;
      GAP:
        // GAP_CYCLES+1 cycles here keeps CONFIG_EN GAP_CYCLES+2 after CONFIG_END
        if (cnt == CW'(GAP_CYCLES)) begin
          cnt_d = '0;
          if (user_q) begin
            ack_d   = 1'b1;
            state_d = READY;
          end else if (idx == 6'(NUM_CMDS - 1)) begin
            done_d  = 1'b1;
            state_d = READY;
          end else begin
            idx_d   = idx + 6'd1;
            data_d  = table_word(idx + 6'd1);
            state_d = ISSUE;
          end
        end else cnt_d = cnt + 1'b1;
      READY:
        if (start_rise) begin
          go_init = 1'b1;
          done_d  = 1'b0;
        end else if (bus.user_wr_en) begin
          state_d = ISSUE;
          user_d  = 1'b1;
          data_d  = {1'b0, bus.user_wr_addr, bus.user_wr_data};
        end
      ERROR:
        if (start_rise) begin
          state_d = FLUSH;
          cnt_d   = '0;
          terr_d  = 1'b0;
          rerun_d = 1'b1;
        end
      default: state_d = FLUSH;
    endcase
    if (go_init) begin
      state_d = ISSUE;
      idx_d   = '0;
      user_d  = 1'b0;
      data_d  = table_word(6'd0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= FLUSH;
      cnt     <= '0;
      idx     <= '0;
      data_q  <= '0;
      user_q  <= 1'b0;
      done_q  <= 1'b0;
      terr_q  <= 1'b0;
      rerun_q <= 1'b0;
      ack_q   <= 1'b0;
      en_q    <= 1'b0;
      start_q <= 1'b0;
    end else begin
      state   <= state_d;
      cnt     <= cnt_d;
      idx     <= idx_d;
      data_q  <= data_d;
      user_q  <= user_d;
      done_q  <= done_d;
      terr_q  <= terr_d;
      rerun_q <= rerun_d;
      ack_q   <= ack_d;
      en_q    <= (state_d == ISSUE);
      start_q <= bus.start;
    end
  end

  assign bus.config_en   = en_q;
  assign bus.config_data = data_q;
  assign bus.user_wr_ack = ack_q;
  assign bus.init_done   = done_q;
  assign bus.timeout_err = terr_q;
  assign bus.cmd_index   = idx;
  assign bus.busy        = (state != READY);
endmodule

// File: tb/tb_ad9122_init_seq.sv
// Directed-sequence bench with randomized serial-stage latency and user words,
// checked against an expected-frame-list model and a per-frame protocol monitor.
module tb_ad9122_init_seq;
  localparam int NUM_CMDS = 16;
  localparam int GAP      = 4;
  localparam int TMO      = 255;

  typedef logic [15:0] wq_t[$];

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   mon_viol = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ad9122_init_seq_if bus();

  ad9122_init_seq #(
    .NUM_CMDS(NUM_CMDS), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TMO), .AUTO_START(1'b1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  logic [15:0] tbl [NUM_CMDS] = '{
    16'h0020, 16'h0000, 16'h0100, 16'h0300, 16'h0400, 16'h0500, 16'h0A80, 16'h0C12,
    16'h0D00, 16'h1600, 16'h17C0, 16'h1B24, 16'h1C00, 16'h1D00, 16'h1E00, 16'h4000};

  // serial-stage model + frame monitor state
  logic [15:0] frames[$];
  int          en_cyc[$];
  int          lat_fix = 64;
  bit          suppress3 = 1'b0;
  bit          end_pend = 1'b0;
  int          end_due = 0;
  int          last_end = -1000;
  bit          prev_en = 1'b0, prev_ack = 1'b0, frame_act = 1'b0, frame_ended = 1'b0;
  logic [15:0] fdata = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic wq_t init_words(input int n);
    wq_t q;
    for (int i = 0; i < n; i++) q.push_back(tbl[i]);
    return q;
  endfunction

  task automatic chk_frames(input string tag, input int base, input wq_t exp);
    chk({tag, "_count"}, frames.size() - base, exp.size());
    for (int i = 0; i < exp.size() && base + i < frames.size(); i++)
      chk($sformatf("%s_w%0d", tag, i), frames[base + i], exp[i]);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_en"},    bus.config_en,   1'b0);
    chk({tag, "_data"},  bus.config_data, 16'h0000);
    chk({tag, "_ack"},   bus.user_wr_ack, 1'b0);
    chk({tag, "_done"},  bus.init_done,   1'b0);
    chk({tag, "_terr"},  bus.timeout_err, 1'b0);
    chk({tag, "_idx"},   bus.cmd_index,   6'd0);
    chk({tag, "_busy"},  bus.busy,        1'b1);
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    while (!(bus.init_done === 1'b1 && bus.busy === 1'b0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(tag, {bus.init_done, bus.busy}, 2'b10);
  endtask

  task automatic user_write(input string tag, input logic [6:0] a, input logic [7:0] d);
    int  base = frames.size();
    int  n = 0;
    int  gap;
    wq_t e;
    bus.user_wr_addr = a;
    bus.user_wr_data = d;
    bus.user_wr_en   = 1'b1;
    while (bus.user_wr_ack !== 1'b1 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    bus.user_wr_en = 1'b0;
    chk({tag, "_ack"}, bus.user_wr_ack, 1'b1);
    gap = cyc - last_end;
    chk({tag, "_ack_pos"}, (gap >= GAP + 1 && gap <= GAP + 2), 1'b1);
    e.push_back({1'b0, a, d});
    chk_frames(tag, base, e);
    @(negedge clk);
    chk({tag, "_ack_w"}, bus.user_wr_ack, 1'b0);
    chk({tag, "_ready"}, {bus.init_done, bus.busy}, 2'b10);
  endtask

  // serial stage: CONFIG_END lat cycles after each CONFIG_EN; frame protocol monitor
  initial begin
    bus.config_end = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        end_pend = 1'b0; bus.config_end = 1'b0; frame_act = 1'b0;
        prev_en = 1'b0; prev_ack = 1'b0; last_end = -1000;
      end else begin
        bus.config_end = end_pend && (cyc == end_due);
        if (bus.config_end) begin
          end_pend = 1'b0; last_end = cyc; frame_ended = 1'b1;
        end
        if (frame_act) begin
          if (bus.config_data !== fdata) mon_viol++;
          if (bus.timeout_err || (frame_ended && cyc >= last_end + GAP + 1)) frame_act = 1'b0;
        end
        if (bus.config_en) begin
          if (prev_en) mon_viol++;
          if (cyc - last_end < GAP + 2) mon_viol++;
          frames.push_back(bus.config_data);
          en_cyc.push_back(cyc);
          fdata = bus.config_data; frame_act = 1'b1; frame_ended = 1'b0;
          if (!(suppress3 && bus.cmd_index == 6'd3)) begin
            end_pend = 1'b1;
            end_due  = cyc + ((lat_fix > 0) ? lat_fix : int'($urandom_range(1, 200)));
          end
        end
        if (bus.user_wr_ack && prev_ack) mon_viol++;
        prev_en  = bus.config_en;
        prev_ack = bus.user_wr_ack;
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: observed no completion, required finish within budget");
    $fatal(1);
  end

  initial begin
    int          base, rel, n, t_cyc, done_cyc, s_cyc;
    logic [6:0]  ua;
    logic [7:0]  ud;
    wq_t         e;
    bus.start = 1'b0; bus.user_wr_en = 1'b0; bus.user_wr_addr = '0; bus.user_wr_data = '0;
    repeat (4) @(negedge clk);
    chk_reset("rst");

    // power-up init with fixed 64-cycle serial stage; user request during init ignored
    base = frames.size();
    rst = 1'b0; rel = cyc;
    repeat (100) @(negedge clk);
    bus.user_wr_addr = 7'($urandom); bus.user_wr_data = 8'($urandom); bus.user_wr_en = 1'b1;
    repeat (300) @(negedge clk);
    bus.user_wr_en = 1'b0;
    wait_done("init_done", 5000);
    if (frames.size() > base) chk("first_en_cycle", en_cyc[base] - rel + 1, 65);
    chk_frames("init", base, init_words(NUM_CMDS));
    chk("init_idx", bus.cmd_index, 6'(NUM_CMDS - 1));

    // runtime writes, random serial latency
    lat_fix = 0;
    user_write("uw_1ba5", 7'h1B, 8'hA5);
    for (int i = 0; i < 4; i++) user_write($sformatf("uw_rnd%0d", i), 7'($urandom), 8'($urandom));

    // START and USER_WR_EN together: init wins, user write follows; mid-frame START ignored
    base = frames.size();
    ua = 7'($urandom); ud = 8'($urandom);
    bus.user_wr_addr = ua; bus.user_wr_data = ud; bus.user_wr_en = 1'b1; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    chk("coin_done_clr", bus.init_done, 1'b0);
    chk("coin_idx0", bus.cmd_index, 6'd0);
    repeat (200) @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    n = 0;
    while (bus.init_done !== 1'b1 && n < 6000) begin @(negedge clk); n++; end
    done_cyc = cyc;
    n = 0;
    while (bus.user_wr_ack !== 1'b1 && n < 1000) begin @(negedge clk); n++; end
    bus.user_wr_en = 1'b0;
    chk("coin_ack", bus.user_wr_ack, 1'b1);
    e = init_words(NUM_CMDS);
    e.push_back({1'b0, ua, ud});
    chk_frames("coin", base, e);
    if (frames.size() == base + NUM_CMDS + 1)
      chk("coin_user_after_done", en_cyc[base + NUM_CMDS] > done_cyc, 1'b1);
    @(negedge clk);

    // timeout on entry 3, then START recovery
    suppress3 = 1'b1;
    base = frames.size();
    bus.start = 1'b1; @(negedge clk); bus.start = 1'b0;
    n = 0;
    while (bus.timeout_err !== 1'b1 && n < 5000) begin @(negedge clk); n++; end
    t_cyc = cyc;
    chk("tmo_set", bus.timeout_err, 1'b1);
    if (frames.size() > base + 3) chk("tmo_delay", t_cyc - en_cyc[base + 3], TMO);
    repeat (300) @(negedge clk);
    chk_frames("tmo", base, init_words(4));
    chk("tmo_done", bus.init_done, 1'b0);
    chk("tmo_busy", bus.busy, 1'b1);
    chk("tmo_en", bus.config_en, 1'b0);
    suppress3 = 1'b0;
    base = frames.size();
    s_cyc = cyc;
    bus.start = 1'b1; @(negedge clk); bus.start = 1'b0;
    chk("tmo_clr", bus.timeout_err, 1'b0);
    wait_done("tmo_rerun_done", 6000);
    if (frames.size() > base) chk("tmo_flush_gap", (en_cyc[base] - s_cyc) >= 65, 1'b1);
    chk_frames("tmo_rerun", base, init_words(NUM_CMDS));

    // reset during WAIT_END of entry 5
    lat_fix = 64;
    base = frames.size();
    bus.start = 1'b1; @(negedge clk); bus.start = 1'b0;
    n = 0;
    while (frames.size() < base + 6 && n < 3000) begin @(negedge clk); n++; end
    repeat (20) @(negedge clk);
    chk("pre_rst_idx", bus.cmd_index, 6'd5);
    rst = 1'b1;
    @(negedge clk);
    chk_reset("midrst");
    base = frames.size();
    rst = 1'b0; rel = cyc;
    wait_done("midrst_done", 5000);
    if (frames.size() > base) chk("midrst_first_en", en_cyc[base] - rel + 1, 65);
    chk_frames("midrst", base, init_words(NUM_CMDS));

    chk("frame_monitor", mon_viol, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ad9122_init_seq.md
AD9122_INIT_SEQ -- requirements
Module: ad9122_init_seq

Interface
REQ-001 Parameters SHALL be (name, default, meaning): NUM_CMDS, 16, init-table entries; GAP_CYCLES, 4, idle cycles between frames; TIMEOUT_CYCLES, 255, max wait for CONFIG_END; AUTO_START, 1, start init after reset.
REQ-002 CLK  in  1  single system clock; all logic on rising edge.
REQ-003 RST  in  1  reset, synchronous, active-high.
REQ-004 START  in  1  rising edge re-runs the full init table.
REQ-005 USER_WR_EN  in  1  level request for one runtime register write.
REQ-006 USER_WR_ADDR  in  7  runtime write register address.
REQ-007 USER_WR_DATA  in  8  runtime write data.
REQ-008 USER_WR_ACK  out  1  one-cycle pulse when the runtime write frame completes.
REQ-009 CONFIG_EN  out  1  one-cycle frame-start pulse to the AD9122 serial-port stage.
REQ-010 CONFIG_DATA  out  16  frame word: bit15 R/W (0 = write), bits14:8 address, bits7:0 data.
REQ-011 CONFIG_END  in  1  one-cycle frame-complete pulse from the serial-port stage.
REQ-012 INIT_DONE  out  1  high once every table entry has completed without timeout.
REQ-013 BUSY  out  1  high whenever state is not READY.
REQ-014 TIMEOUT_ERR  out  1  sticky; set when CONFIG_END is not seen within TIMEOUT_CYCLES.
REQ-015 CMD_INDEX  out  6  index of the table entry currently issued or last issued.

Function
REQ-016 States SHALL be FLUSH, IDLE, ISSUE, WAIT_END, GAP, READY, ERROR.
REQ-017 FLUSH: count 64 cycles so any frame in flight in the serial stage completes; then go to ISSUE with CMD_INDEX=0 if AUTO_START=1, else go to IDLE.
REQ-018 IDLE: wait for a START rising edge (START high, previous-cycle START low); then go to ISSUE with CMD_INDEX=0.
REQ-019 Init table: a constant lookup of NUM_CMDS 16-bit words; entry0=16'h0020 (soft reset set); entry1=16'h0000 (soft reset clear); remaining entries from the team register plan.
REQ-020 ISSUE (1 cycle): load CONFIG_DATA from the table entry or from the latched user word; drive CONFIG_EN=1 for that cycle only; go to WAIT_END.
REQ-021 CONFIG_DATA SHALL hold stable from the ISSUE cycle until the GAP state exits, because the serial stage samples it throughout the frame.
REQ-022 WAIT_END: count cycles from 0; on CONFIG_END go to GAP; if the count reaches TIMEOUT_CYCLES first, set TIMEOUT_ERR and go to ERROR.
REQ-023 GAP: wait GAP_CYCLES cycles.
REQ-024 On GAP exit for an init frame: if CMD_INDEX=NUM_CMDS-1, set INIT_DONE and go to READY; otherwise increment CMD_INDEX and go to ISSUE.
REQ-025 On GAP exit for a user frame: pulse USER_WR_ACK for 1 cycle and go to READY.
REQ-026 READY: a START rising edge clears INIT_DONE and restarts init at index 0. Otherwise, USER_WR_EN=1 latches {1'b0, ADDR, DATA} and goes to ISSUE. If START and USER_WR_EN coincide, START wins and the user request stays pending.
REQ-027 USER_WR_EN outside READY SHALL be ignored, not queued; the requester holds it high until USER_WR_ACK and drops it the cycle after.
REQ-028 A START edge in ISSUE, WAIT_END or GAP SHALL be ignored.
REQ-029 ERROR: hold CONFIG_EN=0 and BUSY=1; only a START rising edge exits, clearing TIMEOUT_ERR and restarting init via FLUSH.
REQ-030 CONFIG_END received outside WAIT_END SHALL be ignored.
REQ-031 Frame-to-frame spacing SHALL be at least GAP_CYCLES+2 cycles after CONFIG_END, so each CONFIG_EN is a fresh rising edge.

Reset
REQ-032 While RST=1: state=FLUSH, flush counter cleared, CONFIG_EN=0, CONFIG_DATA=16'h0000, USER_WR_ACK=0, INIT_DONE=0, TIMEOUT_ERR=0, CMD_INDEX=0, BUSY=1.
REQ-033 A reset asserted mid-frame SHALL abandon the frame and discard any latched user word; FLUSH then guarantees no CONFIG_EN is issued for 64 cycles after RST falls.

Verification
REQ-034 Release RST with AUTO_START=1, model the serial stage (CONFIG_END 64 cycles after each CONFIG_EN) -> first CONFIG_EN 65 cycles after RST falls, with CONFIG_DATA=16'h0020; second frame carries 16'h0000; NUM_CMDS pulses in total; then INIT_DONE=1 and BUSY=0.
REQ-035 In READY, USER_WR_EN=1 with ADDR=7'h1B, DATA=8'hA5 -> CONFIG_DATA=16'h1BA5, one CONFIG_EN, USER_WR_ACK one cycle after GAP; USER_WR_EN asserted during init -> no frame.
REQ-036 Suppress CONFIG_END on entry 3 -> TIMEOUT_ERR set 255 cycles after that CONFIG_EN; no further CONFIG_EN; INIT_DONE=0; a START edge clears the error and init re-runs from index 0.
REQ-037 START and USER_WR_EN high in the same READY cycle -> init restarts at index 0; the user write issues only after INIT_DONE reasserts.
REQ-038 Assert RST during WAIT_END of entry 5 -> all outputs return to reset values; no CONFIG_EN for 64 cycles; init restarts at entry 0.
REQ-039 Checker on every frame: CONFIG_EN is exactly 1 cycle wide, CONFIG_DATA is stable from CONFIG_EN until GAP exit, and the spacing rule of REQ-031 holds.
